// File: rtl/i2s_audio_tx.sv
// Philips I2S transmitter: 16-bit stereo in, BCK/LRCK/DATA out, 64 BCK per frame.
// Define I2S_UNSIGNED_IN_EN to accept offset-binary samples (bit 15 inverted on latch).
module i2s_audio_tx #(
  parameter int unsigned CLK_RATE   = 32000000,
  parameter int unsigned AUDIO_RATE = 48000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [15:0] left_in,
  input  logic [15:0] right_in,
  output logic        sample_strobe,
  output logic        i2s_bck,
  output logic        i2s_lrck,
  output logic        i2s_data
);

  localparam logic [32:0] INC = 33'(128 * AUDIO_RATE);
  localparam logic [32:0] LIM = 33'(CLK_RATE);

  if (CLK_RATE < 256 * AUDIO_RATE) begin : g_rate_check
    $error("i2s_audio_tx: CLK_RATE must be at least 256*AUDIO_RATE");
  end

  logic [31:0] acc;
  logic [5:0]  bit_cnt;
  logic [15:0] shadow_l;
  logic [15:0] shadow_r;

  logic [32:0] sum;
  logic        tick;
  logic        fall;
  logic [31:0] acc_next;
  logic [5:0]  cnt_next;
  logic [4:0]  slot;
  logic [4:0]  idx;
  logic [15:0] sel;
  logic        bit_next;
  logic [15:0] left_load;
  logic [15:0] right_load;

`ifdef I2S_UNSIGNED_IN_EN
  assign left_load  = {~left_in[15], left_in[14:0]};
  assign right_load = {~right_in[15], right_in[14:0]};
`else
  assign left_load  = left_in;
  assign right_load = right_in;
`endif

  always_comb begin
    sum      = {1'b0, acc} + INC;
    tick     = (sum >= LIM);
    fall     = tick & i2s_bck;
    acc_next = tick ? 32'(sum - LIM) : 32'(sum);
    cnt_next = bit_cnt + 6'd1;
    slot     = cnt_next[4:0];
    idx      = 5'd16 - slot;
    sel      = cnt_next[5] ? shadow_r : shadow_l;
    bit_next = 1'b0;
    // Slot 0 is the one-bit I2S delay, 1..16 carry MSB..LSB, the rest pad with zeros.
    if (slot >= 5'd1 && slot <= 5'd16)
      bit_next = sel[idx[3:0]];
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      acc           <= '0;
      i2s_bck       <= 1'b0;
      bit_cnt       <= 6'd63;
      shadow_l      <= '0;
      shadow_r      <= '0;
      i2s_lrck      <= 1'b0;
      i2s_data      <= 1'b0;
      sample_strobe <= 1'b0;
    end else begin
      sample_strobe <= 1'b0;
      acc           <= acc_next;
      if (tick)
        i2s_bck <= ~i2s_bck;
      if (fall) begin
        bit_cnt  <= cnt_next;
        i2s_lrck <= cnt_next[5];
        i2s_data <= bit_next;
        if (bit_cnt == 6'd63) begin
          shadow_l      <= left_load;
          shadow_r      <= right_load;
          sample_strobe <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Directed bench for i2s_audio_tx: reset, frame content, mid-frame changes and a fractional rate.
module tb_i2s_audio_tx;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        reset_n_f = 1'b0;
  logic [15:0] left_in = 16'hA5C3;
  logic [15:0] right_in = 16'h0F0F;
  logic        sample_strobe, i2s_bck, i2s_lrck, i2s_data;
  logic        strobe_f, bck_f, lrck_f, data_f;

  int n_tests = 0;
  int n_fail  = 0;

  localparam int unsigned F_CLK  = 32000000;
  localparam int unsigned F_RATE = 48000;
  localparam int HP_LO = F_CLK / (128 * F_RATE);
  localparam int HP_HI = HP_LO + 1;

  always #5 clk = ~clk;

  i2s_audio_tx #(.CLK_RATE(12288000), .AUDIO_RATE(48000)) dut (
    .clk_sys(clk), .reset_n(reset_n), .left_in(left_in), .right_in(right_in),
    .sample_strobe(sample_strobe), .i2s_bck(i2s_bck), .i2s_lrck(i2s_lrck), .i2s_data(i2s_data)
  );

  i2s_audio_tx #(.CLK_RATE(F_CLK), .AUDIO_RATE(F_RATE)) dut_frac (
    .clk_sys(clk), .reset_n(reset_n_f), .left_in(left_in), .right_in(right_in),
    .sample_strobe(strobe_f), .i2s_bck(bck_f), .i2s_lrck(lrck_f), .i2s_data(data_f)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] conv(input logic [15:0] x);
`ifdef I2S_UNSIGNED_IN_EN
    return {~x[15], x[14:0]};
`else
    return x;
`endif
  endfunction

  // Call at a negedge where sample_strobe is high; returns at the next strobe.
  task automatic capture(output logic [63:0] d, output logic [63:0] lr, output int period);
    int  bits = 0;
    bit  done = 0;
    logic prev = i2s_bck;
    d = '0; lr = '0; period = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      period++;
      if (i2s_bck && !prev && bits < 64) begin
        d  = {d[62:0], i2s_data};
        lr = {lr[62:0], i2s_lrck};
        bits++;
      end
      prev = i2s_bck;
      if (sample_strobe) begin
        done = 1;
        break;
      end
    end
    if (!done) check("frame_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_frame(input string tag, input logic [15:0] l, input logic [15:0] r);
    logic [63:0] d, lr;
    int period;
    capture(d, lr, period);
    check({tag, "_data"}, d, {1'b0, conv(l), 15'd0, 1'b0, conv(r), 15'd0});
    check({tag, "_lrck"}, lr, {32'h0, 32'hFFFF_FFFF});
    check({tag, "_period"}, 64'(period), 64'd256);
  endtask

  // Call at the negedge where reset_n has just been released.
  task automatic restart_check(input string tag);
    logic [3:0] bck_exp = 4'b0110;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check({tag, "_bck"}, 64'(i2s_bck), 64'(bck_exp[k-1]));
      check({tag, "_strobe"}, 64'(sample_strobe), 64'(k == 4));
    end
    check({tag, "_lrck"}, 64'(i2s_lrck), 64'd0);
  endtask

  task automatic wait_falls(input int n);
    int falls = 0;
    logic prev = i2s_bck;
    for (int c = 0; c < 1000 && falls < n; c++) begin
      @(negedge clk);
      if (prev && !i2s_bck) falls++;
      prev = i2s_bck;
    end
    if (falls < n) check("fall_timeout", 64'(falls), 64'(n));
  endtask

  initial begin
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_outs", {60'd0, i2s_bck, i2s_lrck, i2s_data, sample_strobe}, 64'd0);
    end
    reset_n = 1'b1;
    restart_check("start");

    run_frame("pat", 16'hA5C3, 16'h0F0F);
    left_in = 16'h1234;
    run_frame("pat2", 16'hA5C3, 16'h0F0F);

    fork
      run_frame("mid1", 16'h1234, 16'h0F0F);
      begin
        repeat (20) @(negedge clk);
        left_in = 16'hFFFF;
      end
    join
    run_frame("mid2", 16'hFFFF, 16'h0F0F);

    left_in  = 16'h8000;
    right_in = 16'h0000;
    run_frame("sgn_settle", 16'hFFFF, 16'h0F0F);
    run_frame("sgn", 16'h8000, 16'h0000);

    // Now at bit_cnt 0; advance to bit_cnt 40 inside the right slot.
    wait_falls(40);
    check("pre_rst_lrck", 64'(i2s_lrck), 64'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_outs", {60'd0, i2s_bck, i2s_lrck, i2s_data, sample_strobe}, 64'd0);
    reset_n = 1'b1;
    restart_check("restart");
    run_frame("after_rst", 16'h8000, 16'h0000);

    begin
      int cyc = 0, last_tog = 0, toggles = 0, bad = 0, strobes = 0, t_first = 0, t_last = 0;
      logic prev;
      @(negedge clk);
      reset_n_f = 1'b1;
      prev = bck_f;
      for (int c = 0; c < 30000 && strobes < 31; c++) begin
        @(negedge clk);
        cyc++;
        if (bck_f != prev) begin
          if (toggles > 0 && (cyc - last_tog < HP_LO || cyc - last_tog > HP_HI)) bad++;
          toggles++;
          last_tog = cyc;
        end
        prev = bck_f;
        if (strobe_f) begin
          strobes++;
          if (strobes == 1) t_first = cyc;
          t_last = cyc;
        end
      end
      check("frac_strobes", 64'(strobes), 64'd31);
      check("frac_halfper", 64'(bad), 64'd0);
      check("frac_span", 64'(t_last - t_first), 64'd20000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
